// File: rtl/sr_piso_tx_pkg.sv
// Shared definitions for the serial link: FSM state encodings and default word width.
package sr_piso_tx_pkg;

    typedef enum logic [1:0] {
        SR_IDLE  = 2'd0,
        SR_SHIFT = 2'd1,
        SR_GAP   = 2'd2
    } sr_state_e;

    localparam int SR_DEFAULT_WIDTH = 4;

    // Bits needed to hold a count of n-1 (at least one bit).
    function automatic int sr_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr_bit_counter.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module sr_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sr_piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per clock,
// framed by a bit counter, with an optional forced idle gap between words.
module sr_piso_tx
    import sr_piso_tx_pkg::*;
#(
    parameter int WIDTH     = SR_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int                CNT_W    = sr_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]        GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    sr_state_e        state;
    sr_state_e        state_next;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             bit_zero;
    logic             bit_load;
    logic             bit_dec;
    logic [3:0]       gap_cnt_unused;
    logic             gap_zero;
    logic             gap_load;
    logic             gap_dec;
    logic             shreg_load;
    logic             shreg_shift;
    logic             accept;

    assign accept = load_valid && load_ready;

    sr_bit_counter #(.W(CNT_W)) u_bit_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (bit_load),
        .load_val (BIT_LAST),
        .dec      (bit_dec),
        .count    (bit_cnt),
        .zero     (bit_zero)
    );

    sr_bit_counter #(.W(4)) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .count    (gap_cnt_unused),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        bit_load    = 1'b0;
        bit_dec     = 1'b0;
        gap_load    = 1'b0;
        gap_dec     = 1'b0;
        shreg_load  = 1'b0;
        shreg_shift = 1'b0;
        case (state)
            SR_IDLE: begin
                if (accept) begin
                    state_next = SR_SHIFT;
                    bit_load   = 1'b1;
                    shreg_load = 1'b1;
                end
            end
            SR_SHIFT: begin
                if (!bit_zero) begin
                    bit_dec     = 1'b1;
                    shreg_shift = 1'b1;
                end else if (GAP > 0) begin
                    state_next = SR_GAP;
                    gap_load   = 1'b1;
                end else if (accept) begin
                    // Back-to-back reload on the last bit: no bubble between words.
                    bit_load   = 1'b1;
                    shreg_load = 1'b1;
                end else begin
                    state_next = SR_IDLE;
                end
            end
            SR_GAP: begin
                if (gap_zero) begin
                    state_next = SR_IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_next = SR_IDLE;
        endcase
    end

    always_comb begin
        load_ready  = 1'b0;
        sout        = 1'b0;
        sout_valid  = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        busy        = (state != SR_IDLE);
        case (state)
            // Held low while reset is asserted so nothing is offered during reset.
            SR_IDLE: load_ready = !reset;
            SR_SHIFT: begin
                sout_valid  = 1'b1;
                sout        = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                frame_start = (bit_cnt == BIT_LAST);
                frame_done  = bit_zero;
                load_ready  = bit_zero && (GAP == 0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (shreg_load) begin
            shreg <= din;
        end else if (shreg_shift) begin
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_sr_piso_tx.sv
// Scoreboard bench for sr_piso_tx: three instances (MSB-first, LSB-first, GAP=2)
// share clock and reset; expected bits are queued at accept and popped by a monitor.
module tb_sr_piso_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din [3];
    logic       lv  [3];
    logic       rdy [3];
    logic       so  [3];
    logic       sv  [3];
    logic       fs  [3];
    logic       fd  [3];
    logic       bz  [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc [3];

    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] q2[$];

    logic [3:0] sipo = 4'd0;
    logic       sipo_arm = 1'b0;
    logic [3:0] sipo_exp = 4'd0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sr_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) u0 (
        .clk(clk), .reset(reset), .din(din[0]), .load_valid(lv[0]), .load_ready(rdy[0]),
        .sout(so[0]), .sout_valid(sv[0]), .frame_start(fs[0]), .frame_done(fd[0]), .busy(bz[0])
    );
    sr_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(0)) u1 (
        .clk(clk), .reset(reset), .din(din[1]), .load_valid(lv[1]), .load_ready(rdy[1]),
        .sout(so[1]), .sout_valid(sv[1]), .frame_start(fs[1]), .frame_done(fd[1]), .busy(bz[1])
    );
    sr_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(2)) u2 (
        .clk(clk), .reset(reset), .din(din[2]), .load_valid(lv[2]), .load_ready(rdy[2]),
        .sout(so[2]), .sout_valid(sv[2]), .frame_start(fs[2]), .frame_done(fd[2]), .busy(bz[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit pop(input int k, output logic [2:0] e);
        e = 3'b000;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    // Expected entry per bit: {sout, frame_start, frame_done}.
    task automatic push_word(input int k, input logic [3:0] w);
        logic [2:0] e;
        logic       b;
        for (int i = 0; i < 4; i++) begin
            b = (k == 1) ? w[i] : w[3-i];
            e = {b, (i == 0), (i == 3)};
            case (k)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    // Monitor: every valid bit must match the head of its instance's queue.
    always @(negedge clk) begin
        logic [2:0] e;
        for (int k = 0; k < 3; k++) begin
            if (sv[k] === 1'b1) begin
                if (!pop(k, e)) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_bit inst=%0d actual={%b,%b,%b} required=none",
                             k, so[k], fs[k], fd[k]);
                end else begin
                    chk($sformatf("bit_inst%0d", k), {29'd0, so[k], fs[k], fd[k]}, {29'd0, e});
                end
            end
        end
        if (sv[0] === 1'b1) begin
            sipo <= {sipo[2:0], so[0]};
            if (sipo_arm && fd[0] === 1'b1)
                chk("sipo_q", {28'd0, sipo[2:0], so[0]}, {28'd0, sipo_exp});
        end
    end

    task automatic send(input int k, input logic [3:0] w);
        int n;
        n = 0;
        din[k] = w;
        lv[k]  = 1'b1;
        while (rdy[k] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL send_timeout inst=%0d actual=no_ready required=ready", k);
            lv[k] = 1'b0;
            return;
        end
        push_word(k, w);
        acc[k] = cyc + 1;
        @(negedge clk);
        lv[k] = 1'b0;
        chk($sformatf("first_bit_inst%0d", k), {30'd0, sv[k], fs[k]}, 32'd3);
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_idle(input string name, input int k);
        chk(name, {29'd0, rdy[k], bz[k], sv[k]}, 32'b100);
    endtask

    task automatic chk_all_zero(input string name);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_inst%0d", name, k),
                {26'd0, rdy[k], so[k], sv[k], fs[k], fd[k], bz[k]}, 32'd0);
    endtask

    initial begin
        int a;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din[k] = 4'd0;
            lv[k]  = 1'b0;
            acc[k] = 0;
        end
        @(negedge clk);
        chk_all_zero("reset_outputs");
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk_idle($sformatf("post_reset_idle%0d", k), k);

        // MSB-first single word: 1,0,1,1.
        send(0, 4'b1011);
        wait_neg(3);
        chk("last_bit_ready_gap0", {31'd0, rdy[0]}, 32'd1);
        @(negedge clk);
        chk_idle("idle_after_word", 0);

        // LSB-first single word: 1,1,0,1.
        send(1, 4'b1011);
        wait_neg(4);
        chk_idle("idle_after_lsb_word", 1);

        // Back-to-back with no bubble.
        send(0, 4'b1011);
        a = acc[0];
        send(0, 4'b0110);
        chk("b2b_spacing", acc[0] - a, 32'd4);
        wait_neg(4);
        chk_idle("idle_after_b2b", 0);

        // GAP=2: two forced idle cycles between words, load_valid held.
        send(2, 4'b1011);
        a = acc[2];
        din[2] = 4'b0110;
        lv[2]  = 1'b1;
        wait_neg(3);
        chk("last_bit_ready_gap2", {31'd0, rdy[2]}, 32'd0);
        @(negedge clk);
        chk("gap_cycle1", {29'd0, sv[2], rdy[2], bz[2]}, 32'b001);
        @(negedge clk);
        chk("gap_cycle2", {29'd0, sv[2], rdy[2], bz[2]}, 32'b001);
        send(2, 4'b0110);
        chk("gap_spacing", acc[2] - a, 32'd7);
        wait_neg(7);
        chk_idle("idle_after_gap", 2);

        // Loads offered mid-frame are ignored.
        send(0, 4'b1111);
        din[0] = 4'b0000;
        lv[0]  = 1'b1;
        @(negedge clk);
        lv[0]  = 1'b0;
        @(negedge clk);
        lv[0]  = 1'b1;
        @(negedge clk);
        lv[0]  = 1'b0;
        wait_neg(2);
        chk_idle("idle_after_ignore", 0);

        // Asynchronous reset mid-frame, then a clean word.
        send(0, 4'b1001);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        q0.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, rdy[0]}, 32'd1);
        sipo_exp = 4'b0101;
        sipo_arm = 1'b1;
        send(0, 4'b0101);
        wait_neg(5);
        chk_idle("idle_final", 0);

        chk("queues_drained", q0.size() + q1.size() + q2.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
